// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM state,
// request owner encoding and the latency counter width.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_e;

    localparam int CNT_W = 4;

endpackage : mem_arb_pkg

// File: rtl/arb_pick.sv
// Combinational grant selection between the fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating priority on conflicts; otherwise data wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_valid_i,
    input  logic   d_valid_i,
    input  owner_e last_grant_i,
    output owner_e grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a conflict the port that did not win last time gets the memory
    always_comb begin
        grant_o = NONE;
        if (i_valid_i && d_valid_i) begin
            grant_o = (last_grant_i == DATA) ? FETCH : DATA;
        end else if (d_valid_i) begin
            grant_o = DATA;
        end else if (i_valid_i) begin
            grant_o = FETCH;
        end else begin
            grant_o = NONE;
        end
    end
`else
    logic unused_last_grant_s;
    assign unused_last_grant_s = ^last_grant_i;

    // Fixed priority: data side always beats fetch
    always_comb begin
        grant_o = NONE;
        if (d_valid_i) begin
            grant_o = DATA;
        end else if (i_valid_i) begin
            grant_o = FETCH;
        end else begin
            grant_o = NONE;
        end
    end
`endif

endmodule : arb_pick

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store requesters.
// Optional round-robin arbitration on conflicts via macro ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_valid,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           grant_s;

    arb_pick u_arb_pick (
        .i_valid_i    (i_valid),
        .d_valid_i    (d_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s)
    );

    // State, owner, last grant and latency counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= NONE;
            last_grant_q <= DATA;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic and memory/requester muxing; outputs forced low during reset
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        i_ready      = 1'b0;
        i_rdata      = '0;
        d_ready      = 1'b0;
        d_rdata      = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        busy         = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    case (grant_s)
                        DATA: begin
                            mem_en       = 1'b1;
                            mem_addr     = d_addr;
                            last_grant_d = DATA;
                            if (d_we) begin
                                // Stores retire in the issue cycle; the port stays free
                                mem_we    = 1'b1;
                                mem_wdata = d_wdata;
                                mem_wstrb = d_wstrb;
                                d_ready   = 1'b1;
                            end else begin
                                owner_d = DATA;
                                cnt_d   = CNT_W'(MEM_LAT - 1);
                                state_d = WAIT;
                            end
                        end
                        FETCH: begin
                            mem_en       = 1'b1;
                            mem_addr     = i_addr;
                            last_grant_d = FETCH;
                            owner_d      = FETCH;
                            cnt_d        = CNT_W'(MEM_LAT - 1);
                            state_d      = WAIT;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
                WAIT: begin
                    busy = 1'b1;
                    if (cnt_q == '0) begin
                        // Read data returns now; hand it only to the owning port
                        state_d = IDLE;
                        owner_d = NONE;
                        if (owner_q == FETCH) begin
                            i_ready = 1'b1;
                            i_rdata = mem_rdata;
                        end else if (owner_q == DATA) begin
                            d_ready = 1'b1;
                            d_rdata = mem_rdata;
                        end else begin
                            owner_d = NONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            endcase
        end else begin
            state_d = IDLE;
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timing model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int LAT = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_valid;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    // Model: cycles left until read data returns (0 = memory free), owner 1=fetch 2=data
    int m_wait   = 0;
    int m_owner  = 0;
    int m_last   = 2;
    logic i_seen = 1'b0;
    logic d_seen = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_mem_en"}, mem_en, 1'b0);
        check_eq({tag, "_mem_we"}, mem_we, 1'b0);
        check_eq({tag, "_mem_addr"}, mem_addr, '0);
        check_eq({tag, "_i_ready"}, i_ready, 1'b0);
        check_eq({tag, "_d_ready"}, d_ready, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    // Evaluate one cycle with current inputs: compare outputs, then advance model
    task automatic model_cycle();
        logic          e_en, e_we, e_ir, e_dr, e_busy;
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_strb;
        logic [DW-1:0] e_wd, e_ird, e_drd;
        int            win;
        e_en = 1'b0; e_we = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_strb = '0; e_wd = '0; e_ird = '0; e_drd = '0;
        win = 0;
        if (m_wait > 0) begin
            e_busy = 1'b1;
            if (m_wait == 1) begin
                if (m_owner == 1) begin e_ir = 1'b1; e_ird = mem_rdata; end
                else begin e_dr = 1'b1; e_drd = mem_rdata; end
            end
            m_wait--;
        end else begin
            if (d_valid && i_valid) win = RR ? ((m_last == 2) ? 1 : 2) : 2;
            else if (d_valid) win = 2;
            else if (i_valid) win = 1;
            if (win != 0) begin
                e_en   = 1'b1;
                m_last = win;
                e_addr = (win == 2) ? d_addr : i_addr;
                if (win == 2 && d_we) begin
                    e_we = 1'b1; e_dr = 1'b1; e_strb = d_wstrb; e_wd = d_wdata;
                end else begin
                    m_wait  = LAT;
                    m_owner = win;
                end
            end
        end
        check_eq("mem_en", mem_en, e_en);
        check_eq("mem_we", mem_we, e_we);
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wstrb", mem_wstrb, e_strb);
        check_eq("mem_wdata", mem_wdata, e_wd);
        check_eq("i_ready", i_ready, e_ir);
        check_eq("i_rdata", i_rdata, e_ird);
        check_eq("d_ready", d_ready, e_dr);
        check_eq("d_rdata", d_rdata, e_drd);
        check_eq("busy", busy, e_busy);
    endtask

    // One clock of requester behaviour: drop valid after a handshake, maybe raise a new request
    task automatic step(input bit allow_new);
        @(negedge clk);
        if (i_seen) i_valid = 1'b0;
        if (d_seen) d_valid = 1'b0;
        if (allow_new && !i_valid && $urandom_range(0, 2) == 0) begin
            i_valid = 1'b1;
            i_addr  = $urandom;
        end
        if (allow_new && !d_valid && $urandom_range(0, 2) == 0) begin
            d_valid = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = SW'($urandom);
        end
        mem_rdata = $urandom;
        #1;
        model_cycle();
        i_seen = i_ready;
        d_seen = d_ready;
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b1; i_addr = 32'h0000_0040;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200;
        d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; mem_rdata = 32'h1234_5678;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        i_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0;
        rst = 1'b0;
        #1;
        check_all_zero("post_reset_idle");

        for (int c = 0; c < 3000; c++) step(1'b1);

        // Drain outstanding traffic
        for (int c = 0; c < 4 * (LAT + 2); c++) step(1'b0);

        // Reset during an in-flight fetch
        @(negedge clk);
        i_valid = 1'b1; i_addr = 32'h0000_0010; mem_rdata = 32'h0;
        #1;
        model_cycle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_read_reset");
        m_wait = 0; m_owner = 0; m_last = 2;
        i_valid = 1'b0;
        i_seen = 1'b0; d_seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) step(1'b0);

        // Fresh fetch after reset completes with the memory's data
        @(negedge clk);
        i_valid = 1'b1; i_addr = 32'h0000_0010;
        #1;
        model_cycle();
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            mem_rdata = 32'h0000_0013;
            #1;
            model_cycle();
        end
        check_eq("fresh_fetch_data", i_rdata, 32'h0000_0013);
        i_valid = 1'b0;
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
